// File: rtl/rggen_apb_slave_adapter_if.sv
// APB slave-side bundle used by rggen_apb_slave_adapter.
// Parameterised on address and data width; strobe is BUS_WIDTH/8.
interface rggen_apb_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);
  logic                   psel;
  logic                   penable;
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic [2:0]             pprot;
  logic                   pwrite;
  logic [BUS_WIDTH/8-1:0] pstrb;
  logic [BUS_WIDTH-1:0]   pwdata;
  logic                   pready;
  logic [BUS_WIDTH-1:0]   prdata;
  logic                   pslverr;

  modport slave (
    input  psel, penable, paddr, pprot,
    input  pwrite, pstrb, pwdata,
    output pready, prdata, pslverr
  );

  modport master (
    output psel, penable, paddr, pprot,
    output pwrite, pstrb, pwdata,
    input  pready, prdata, pslverr
  );
endinterface

// File: rtl/rggen_apb_slave_adapter.sv
// APB slave to rggen register-bus bridge (IDLE/REQUEST/RESPONSE).
// Optional wait limit enabled by RGGEN_APB_SLAVE_ADAPTER_TIMEOUT_EN.
module rggen_apb_slave_adapter #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 256
)(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  rggen_apb_if.slave               apb_if,
  output logic                     o_reg_valid,
  output logic [ADDRESS_WIDTH-1:0] o_reg_address,
  output logic                     o_reg_write,
  output logic [BUS_WIDTH-1:0]     o_reg_write_data,
  output logic [BUS_WIDTH/8-1:0]   o_reg_strobe,
  input  logic                     i_reg_ready,
  input  logic [1:0]               i_reg_status,
  input  logic [BUS_WIDTH-1:0]     i_reg_read_data
);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    RESPONSE
  } state_e;

  state_e               state;
  state_e               state_next;
  logic                 setup;
  logic                 accept;
  logic                 expired;
  logic [BUS_WIDTH-1:0] rsp_data;
  logic                 rsp_error;
  logic                 unused;

  assign setup  = apb_if.psel && !apb_if.penable;
  assign accept = (state == IDLE) && setup;
  assign unused = ^{apb_if.pprot, i_reg_status[0]};

`ifdef RGGEN_APB_SLAVE_ADAPTER_TIMEOUT_EN
  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (accept) begin
      count <= '0;
    end else if ((state == REQUEST) && !i_reg_ready) begin
      count <= count + 16'd1;
    end
  end

  // ready in the limit cycle wins over the timeout
  assign expired = (state == REQUEST) && !i_reg_ready &&
                   (count == LIMIT);
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign expired = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (setup) begin
          state_next = REQUEST;
        end
      end
      REQUEST: begin
        if (i_reg_ready || expired) begin
          state_next = RESPONSE;
        end
      end
      RESPONSE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_reg_address    <= '0;
      o_reg_write      <= 1'b0;
      o_reg_write_data <= '0;
      o_reg_strobe     <= '0;
    end else if (accept) begin
      o_reg_address    <= apb_if.paddr;
      o_reg_write      <= apb_if.pwrite;
      o_reg_write_data <= apb_if.pwdata;
      o_reg_strobe     <= apb_if.pstrb;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_data  <= '0;
      rsp_error <= 1'b0;
    end else if ((state == REQUEST) && i_reg_ready) begin
      rsp_error <= i_reg_status[1];
      rsp_data  <= o_reg_write ? '0 : i_reg_read_data;
    end else if (expired) begin
      rsp_error <= 1'b1;
      rsp_data  <= '0;
    end
  end

  assign o_reg_valid    = (state == REQUEST);
  assign apb_if.pready  = (state == RESPONSE);
  assign apb_if.prdata  = (state == RESPONSE) ? rsp_data : '0;
  assign apb_if.pslverr = (state == RESPONSE) && rsp_error;

endmodule

// File: tb/tb_rggen_apb_slave_adapter.sv
// Directed bench for rggen_apb_slave_adapter.
// Timeout scenario runs only with RGGEN_APB_SLAVE_ADAPTER_TIMEOUT_EN.
module tb_rggen_apb_slave_adapter;

  logic        clk;
  logic        rst_n;
  logic        reg_valid;
  logic [15:0] reg_address;
  logic        reg_write;
  logic [31:0] reg_write_data;
  logic [3:0]  reg_strobe;
  logic        reg_ready;
  logic [1:0]  reg_status;
  logic [31:0] reg_read_data;

  int vectors;
  int miscompares;

  int          r_lat;
  logic [31:0] r_prd;
  logic        r_err;
  int          r_vcyc;
  bit          r_stable;
  logic        r_v0;
  logic [15:0] r_addr;
  logic        r_wr;
  logic [31:0] r_wd;
  logic [3:0]  r_st;

  rggen_apb_if #(.ADDRESS_WIDTH(16), .BUS_WIDTH(32)) apb();

  rggen_apb_slave_adapter #(
    .ADDRESS_WIDTH  (16),
    .BUS_WIDTH      (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .apb_if           (apb.slave),
    .o_reg_valid      (reg_valid),
    .o_reg_address    (reg_address),
    .o_reg_write      (reg_write),
    .o_reg_write_data (reg_write_data),
    .o_reg_strobe     (reg_strobe),
    .i_reg_ready      (reg_ready),
    .i_reg_status     (reg_status),
    .i_reg_read_data  (reg_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    apb.psel      = 1'b0;
    apb.penable   = 1'b0;
    apb.paddr     = '0;
    apb.pprot     = '0;
    apb.pwrite    = 1'b0;
    apb.pstrb     = '0;
    apb.pwdata    = '0;
    reg_ready     = 1'b0;
    reg_status    = '0;
    reg_read_data = '0;
  endtask

  // Drives one APB transfer; ready is given on request cycle rdy_at
  // (0-based, -1 = never). Results land in the r_* variables.
  task automatic xfer(
    input logic [15:0] addr, input logic wr,
    input logic [31:0] wd, input logic [3:0] st,
    input int rdy_at, input logic [1:0] status,
    input logic [31:0] rd, input bit abort,
    input bit setup_in_rsp
  );
    r_lat = -1; r_prd = 'x; r_err = 1'bx;
    r_vcyc = 0; r_stable = 1'b1;
    r_addr = '0; r_wr = 1'b0; r_wd = '0; r_st = '0;
    apb.psel = 1'b1; apb.penable = 1'b0;
    apb.paddr = addr; apb.pwrite = wr;
    apb.pwdata = wd; apb.pstrb = st;
    apb.pprot = 3'($urandom_range(7));
    r_v0 = reg_valid;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (abort) begin
        apb.psel = 1'b0; apb.penable = 1'b0;
      end else begin
        apb.penable = 1'b1;
      end
      reg_ready = 1'b0;
      if (reg_valid) begin
        if (r_vcyc == 0) begin
          r_addr = reg_address; r_wr = reg_write;
          r_wd = reg_write_data; r_st = reg_strobe;
        end else if (reg_address !== r_addr ||
                     reg_write !== r_wr ||
                     reg_write_data !== r_wd ||
                     reg_strobe !== r_st) begin
          r_stable = 1'b0;
        end
        if (r_vcyc == rdy_at) begin
          reg_ready = 1'b1;
          reg_status = status;
          reg_read_data = rd;
        end
        r_vcyc++;
      end
      if (apb.pready) begin
        r_lat = c; r_prd = apb.prdata; r_err = apb.pslverr;
        if (setup_in_rsp) begin
          apb.psel = 1'b1; apb.penable = 1'b0;
          apb.paddr = 16'h0bad; apb.pwrite = 1'b1;
        end
        break;
      end
    end
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    vectors++;
    if ({reg_valid, reg_write, apb.pready, apb.pslverr} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 0000",
               {reg_valid, reg_write, apb.pready, apb.pslverr});
    end
    vectors++;
    if ({reg_address, reg_write_data, reg_strobe} !== 52'h0) begin
      miscompares++;
      $display("FAIL reset_regs: got %h expected 0",
               {reg_address, reg_write_data, reg_strobe});
    end
    vectors++;
    if (apb.prdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_prdata: got %h expected 0", apb.prdata);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write();
    xfer(16'h0010, 1'b1, 32'hdeadbeef, 4'hf, 0, 2'b00,
         32'hffffffff, 1'b0, 1'b0);
    vectors++;
    if ({r_addr, r_wr, r_wd, r_st} !== {16'h0010, 1'b1, 32'hdeadbeef, 4'hf}) begin
      miscompares++;
      $display("FAIL write_capture: got %h/%b/%h/%h expected 0010/1/deadbeef/f",
               r_addr, r_wr, r_wd, r_st);
    end
    vectors++;
    if (r_lat !== 2) begin
      miscompares++;
      $display("FAIL write_latency: got %0d expected 2", r_lat);
    end
    vectors++;
    if ({r_err, r_prd} !== 33'h0) begin
      miscompares++;
      $display("FAIL write_rsp: got %b/%h expected 0/00000000", r_err, r_prd);
    end
    vectors++;
    if (apb.pready !== 1'b0) begin
      miscompares++;
      $display("FAIL write_pready_once: got %b expected 0", apb.pready);
    end
  endtask

  task automatic test_read_wait();
    xfer(16'h0020, 1'b0, 32'h0, 4'h0, 2, 2'b00,
         32'h12345678, 1'b0, 1'b0);
    vectors++;
    if (r_lat !== 4) begin
      miscompares++;
      $display("FAIL read_latency: got %0d expected 4", r_lat);
    end
    vectors++;
    if ({r_err, r_prd} !== {1'b0, 32'h12345678}) begin
      miscompares++;
      $display("FAIL read_rsp: got %b/%h expected 0/12345678", r_err, r_prd);
    end
    vectors++;
    if ({r_addr, r_wr, r_vcyc[3:0]} !== {16'h0020, 1'b0, 4'd3}) begin
      miscompares++;
      $display("FAIL read_request: got %h/%b/%0d expected 0020/0/3",
               r_addr, r_wr, r_vcyc);
    end
  endtask

  task automatic test_error_read();
    xfer(16'h0044, 1'b0, 32'h0, 4'h0, 0, 2'b10,
         32'hcafef00d, 1'b0, 1'b0);
    vectors++;
    if ({r_lat[3:0], r_err, r_prd} !== {4'd2, 1'b1, 32'hcafef00d}) begin
      miscompares++;
      $display("FAIL error_read: got %0d/%b/%h expected 2/1/cafef00d",
               r_lat, r_err, r_prd);
    end
  endtask

  task automatic test_setup_in_response();
    xfer(16'h0030, 1'b1, 32'h00000001, 4'h1, 0, 2'b00,
         32'h0, 1'b0, 1'b1);
    vectors++;
    if (reg_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rsp_setup_ignored_a: got %b expected 0", reg_valid);
    end
    step();
    vectors++;
    if (reg_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rsp_setup_ignored_b: got %b expected 0", reg_valid);
    end
  endtask

  task automatic test_abort();
    xfer(16'h0050, 1'b0, 32'h0, 4'h0, 1, 2'b00,
         32'h55aa55aa, 1'b1, 1'b0);
    vectors++;
    if ({r_lat[3:0], r_vcyc[3:0], r_err} !== {4'd3, 4'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL abort_completes: got %0d/%0d/%b expected 3/2/0",
               r_lat, r_vcyc, r_err);
    end
  endtask

  task automatic test_reset_mid_request();
    apb.psel = 1'b1; apb.penable = 1'b0;
    apb.paddr = 16'h0060; apb.pwrite = 1'b1;
    apb.pwdata = 32'h0badcafe; apb.pstrb = 4'h3;
    step();
    apb.penable = 1'b1;
    vectors++;
    if (reg_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_pre: got %b expected 1", reg_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({reg_valid, apb.pready, reg_address} !== {2'b00, 16'h0}) begin
      miscompares++;
      $display("FAIL rst_mid_async: got %b/%b/%h expected 0/0/0000",
               reg_valid, apb.pready, reg_address);
    end
    idle_inputs();
    step();
    rst_n = 1'b1;
    vectors++;
    if ({reg_valid, apb.pready} !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_mid_no_rsp: got %b expected 00",
               {reg_valid, apb.pready});
    end
    step();
    xfer(16'h0064, 1'b1, 32'h11112222, 4'hc, 0, 2'b00,
         32'h0, 1'b0, 1'b0);
    vectors++;
    if ({r_lat[3:0], r_err, r_addr, r_wd} !== {4'd2, 1'b0, 16'h0064, 32'h11112222}) begin
      miscompares++;
      $display("FAIL rst_mid_recover: got %0d/%b/%h/%h expected 2/0/0064/11112222",
               r_lat, r_err, r_addr, r_wd);
    end
  endtask

  task automatic test_back_to_back();
    xfer(16'h0100, 1'b1, 32'haaaa0001, 4'hf, 1, 2'b00,
         32'h0, 1'b0, 1'b0);
    vectors++;
    if ({r_stable, r_vcyc[3:0], r_lat[3:0], r_addr} !== {1'b1, 4'd2, 4'd3, 16'h0100}) begin
      miscompares++;
      $display("FAIL b2b_first: got %b/%0d/%0d/%h expected 1/2/3/0100",
               r_stable, r_vcyc, r_lat, r_addr);
    end
    xfer(16'h0104, 1'b1, 32'hbbbb0002, 4'h5, 2, 2'b00,
         32'h0, 1'b0, 1'b0);
    vectors++;
    if ({r_v0, r_stable, r_vcyc[3:0], r_lat[3:0]} !== {1'b0, 1'b1, 4'd3, 4'd4}) begin
      miscompares++;
      $display("FAIL b2b_second: got %b/%b/%0d/%0d expected 0/1/3/4",
               r_v0, r_stable, r_vcyc, r_lat);
    end
    vectors++;
    if ({r_addr, r_wd, r_st} !== {16'h0104, 32'hbbbb0002, 4'h5}) begin
      miscompares++;
      $display("FAIL b2b_second_capture: got %h/%h/%h expected 0104/bbbb0002/5",
               r_addr, r_wd, r_st);
    end
  endtask

`ifdef RGGEN_APB_SLAVE_ADAPTER_TIMEOUT_EN
  task automatic test_timeout();
    xfer(16'h0200, 1'b0, 32'h0, 4'h0, -1, 2'b00,
         32'h87654321, 1'b0, 1'b0);
    vectors++;
    if ({r_vcyc[3:0], r_lat[3:0], r_err, r_prd} !== {4'd4, 4'd5, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL timeout_expire: got %0d/%0d/%b/%h expected 4/5/1/00000000",
               r_vcyc, r_lat, r_err, r_prd);
    end
    xfer(16'h0204, 1'b0, 32'h0, 4'h0, 3, 2'b00,
         32'h87654321, 1'b0, 1'b0);
    vectors++;
    if ({r_vcyc[3:0], r_lat[3:0], r_err, r_prd} !== {4'd4, 4'd5, 1'b0, 32'h87654321}) begin
      miscompares++;
      $display("FAIL timeout_ready_wins: got %0d/%0d/%b/%h expected 4/5/0/87654321",
               r_vcyc, r_lat, r_err, r_prd);
    end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_write();
    test_read_wait();
    test_error_read();
    test_setup_in_response();
    test_abort();
    test_reset_mid_request();
    test_back_to_back();
`ifdef RGGEN_APB_SLAVE_ADAPTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
